// File: rtl/uart_caps_fifo.sv
// Byte FIFO between a UART receiver and transmitter, with optional lowercase-to-uppercase
// conversion on write, sticky overflow flag and a saturating frame-error drop counter.
module uart_caps_fifo #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CAPS_EN = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [7:0]                 i_data,
    input  logic                       i_valid,
    input  logic                       i_err,
    output logic [7:0]                 o_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_full,
    output logic                       o_overflow,
    input  logic                       i_clr_ovf,
    output logic [7:0]                 o_err_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic [PW-1:0] level;
    logic          full;
    logic          empty;
    logic          good_push;
    logic          pop;
    logic          do_write;
    logic          lost;
    logic [7:0]    wr_byte;

    // Status depends on registered pointers only.
    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == FULL_LVL);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign good_push = i_valid && !i_err;
    assign pop       = !empty && i_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign do_write  = good_push && (!full || pop);
    assign lost      = good_push && full && !pop;

    always_comb begin
        wr_byte = i_data;
        if ((CAPS_EN != 0) && (i_data >= 8'h61) && (i_data <= 8'h7A)) begin
            wr_byte = i_data - 8'h20;
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ovf_d     = ovf_q;
        err_cnt_d = err_cnt_q;
        if (do_write) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (i_clr_ovf) begin
            ovf_d = 1'b0;
        end
        // Set after clear so a same-cycle overflow wins.
        if (lost) begin
            ovf_d = 1'b1;
        end
        if (i_valid && i_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_q     <= ovf_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge i_clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_byte;
        end
    end

    assign o_data     = mem_q[rd_ptr_q[AW-1:0]];
    assign o_valid    = !empty;
    assign o_level    = level;
    assign o_full     = full;
    assign o_overflow = ovf_q;
    assign o_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_uart_caps_fifo.sv
// Directed bench for uart_caps_fifo: a vector table for the main sequences on a DEPTH=8
// instance, plus hand-written reset, error, CAPS_EN=0 and DEPTH=4 wrap-around sequences.
module tb_uart_caps_fifo;

    logic       clk;
    logic       rst_n;
    logic [7:0] data;
    logic       valid;
    logic       err;
    logic       ready;
    logic       clr_ovf;

    logic [7:0] d8_data,  d0_data,  d4_data;
    logic       d8_valid, d0_valid, d4_valid;
    logic [3:0] d8_level, d0_level;
    logic [2:0] d4_level;
    logic       d8_full,  d0_full,  d4_full;
    logic       d8_ovf,   d0_ovf,   d4_ovf;
    logic [7:0] d8_ecnt,  d0_ecnt,  d4_ecnt;

    int checks = 0;
    int errors = 0;

    uart_caps_fifo #(.DEPTH(8), .CAPS_EN(1)) u_d8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .i_err(err),
        .o_data(d8_data), .o_valid(d8_valid), .i_ready(ready), .o_level(d8_level),
        .o_full(d8_full), .o_overflow(d8_ovf), .i_clr_ovf(clr_ovf), .o_err_cnt(d8_ecnt)
    );

    uart_caps_fifo #(.DEPTH(8), .CAPS_EN(0)) u_d0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .i_err(err),
        .o_data(d0_data), .o_valid(d0_valid), .i_ready(ready), .o_level(d0_level),
        .o_full(d0_full), .o_overflow(d0_ovf), .i_clr_ovf(clr_ovf), .o_err_cnt(d0_ecnt)
    );

    uart_caps_fifo #(.DEPTH(4), .CAPS_EN(1)) u_d4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .i_err(err),
        .o_data(d4_data), .o_valid(d4_valid), .i_ready(ready), .o_level(d4_level),
        .o_full(d4_full), .o_overflow(d4_ovf), .i_clr_ovf(clr_ovf), .o_err_cnt(d4_ecnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       e;
        logic       r;
        logic       c;
        logic       chk;
        logic [7:0] hd;
        int         lvl;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic e, input logic r,
                       input logic c, input logic chk, input logic [7:0] hd, input int lvl,
                       input logic ovf);
        vec_t t;
        t.v = v; t.d = d; t.e = e; t.r = r; t.c = c;
        t.chk = chk; t.hd = hd; t.lvl = lvl; t.ovf = ovf;
        vecs.push_back(t);
    endtask

    // Called just after a rising edge; reset pulse stays clear of the next edge.
    task automatic do_reset();
        valid = 1'b0; err = 1'b0; ready = 1'b0; clr_ovf = 1'b0; data = 8'h00;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        valid = 1'b1; err = 1'b0; data = b;
        cycle();
        valid = 1'b0;
    endtask

    initial begin
        int   q[$];
        int   pushed;
        int   cyc;
        logic do_push;

        rst_n = 1'b0;
        valid = 1'b0; err = 1'b0; ready = 1'b0; clr_ovf = 1'b0; data = 8'h00;
        #12;
        check("rst_valid", d8_valid, 0);
        check("rst_level", d8_level, 0);
        check("rst_full", d8_full, 0);
        check("rst_ovf", d8_ovf, 0);
        check("rst_errcnt", d8_ecnt, 0);
        rst_n = 1'b1;
        cycle();

        // Capitalisation.
        add(1, 8'h61, 0, 0, 0, 0, 8'h00, 1, 0);
        add(1, 8'h7A, 0, 0, 0, 0, 8'h00, 2, 0);
        add(1, 8'h41, 0, 0, 0, 0, 8'h00, 3, 0);
        add(1, 8'h7B, 0, 0, 0, 0, 8'h00, 4, 0);
        add(1, 8'h60, 0, 0, 0, 0, 8'h00, 5, 0);
        add(0, 8'h00, 0, 1, 0, 1, 8'h41, 4, 0);
        add(0, 8'h00, 0, 1, 0, 1, 8'h5A, 3, 0);
        add(0, 8'h00, 0, 1, 0, 1, 8'h41, 2, 0);
        add(0, 8'h00, 0, 1, 0, 1, 8'h7B, 1, 0);
        add(0, 8'h00, 0, 1, 0, 1, 8'h60, 0, 0);
        // Overflow: 9 pushes into 8 entries, drain, then clear.
        for (int i = 0; i < 8; i++) add(1, 8'h30 + 8'(i), 0, 0, 0, 0, 8'h00, i + 1, 0);
        add(1, 8'h38, 0, 0, 0, 0, 8'h00, 8, 1);
        for (int i = 0; i < 8; i++) add(0, 8'h00, 0, 1, 0, 1, 8'h30 + 8'(i), 7 - i, 1);
        add(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0);
        // Full with simultaneous push/pop, error while full, set-wins-over-clear.
        for (int i = 0; i < 8; i++) add(1, 8'h40 + 8'(i), 0, 0, 0, 0, 8'h00, i + 1, 0);
        add(1, 8'h55, 0, 1, 0, 1, 8'h40, 8, 0);
        add(1, 8'hAA, 1, 0, 0, 0, 8'h00, 8, 0);
        add(1, 8'h56, 0, 0, 1, 0, 8'h00, 8, 1);
        add(0, 8'h00, 0, 0, 1, 0, 8'h00, 8, 0);
        for (int i = 1; i < 8; i++) add(0, 8'h00, 0, 1, 0, 1, 8'h40 + 8'(i), 8 - i, 0);
        add(0, 8'h00, 0, 1, 0, 1, 8'h55, 0, 0);

        foreach (vecs[k]) begin
            valid = vecs[k].v; data = vecs[k].d; err = vecs[k].e;
            ready = vecs[k].r; clr_ovf = vecs[k].c;
            #1;
            if (vecs[k].chk) check($sformatf("vec%0d_head", k), d8_data, vecs[k].hd);
            cycle();
            check($sformatf("vec%0d_level", k), d8_level, vecs[k].lvl);
            check($sformatf("vec%0d_valid", k), d8_valid, vecs[k].lvl != 0);
            check($sformatf("vec%0d_full", k), d8_full, vecs[k].lvl == 8);
            check($sformatf("vec%0d_ovf", k), d8_ovf, vecs[k].ovf);
        end
        valid = 1'b0; ready = 1'b0; clr_ovf = 1'b0; err = 1'b0;

        // CAPS_EN=0 keeps lowercase; CAPS_EN=1 converts.
        do_reset();
        cycle();
        push(8'h68);
        check("nocaps_head", d0_data, 8'h68);
        check("nocaps_valid", d0_valid, 1);
        check("caps_head", d8_data, 8'h48);

        // Error drops saturate the counter and store nothing.
        do_reset();
        cycle();
        valid = 1'b1; err = 1'b1; data = 8'h61;
        cycle(); cycle();
        check("err_cnt2", d8_ecnt, 2);
        for (int i = 2; i < 300; i++) cycle();
        valid = 1'b0; err = 1'b0;
        check("err_cnt_sat", d8_ecnt, 8'hFF);
        check("err_level", d8_level, 0);
        check("err_valid", d8_valid, 0);

        // Asynchronous reset between edges.
        do_reset();
        cycle();
        push(8'h31); push(8'h32); push(8'h33);
        check("pre_arst_level", d8_level, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", d8_valid, 0);
        check("arst_level", d8_level, 0);
        check("arst_errcnt", d8_ecnt, 0);
        #1;
        rst_n = 1'b1;
        cycle();
        push(8'h61);
        check("post_arst_valid", d8_valid, 1);
        check("post_arst_level", d8_level, 1);
        check("post_arst_head", d8_data, 8'h41);

        // Wrap-around on DEPTH=4 with random spacing.
        do_reset();
        cycle();
        pushed = 0;
        cyc = 0;
        while ((pushed < 20 || q.size() != 0) && cyc < 1000) begin
            do_push = (pushed < 20) && (q.size() < 4) && ($urandom_range(0, 2) != 0);
            ready = ($urandom_range(0, 2) == 0);
            valid = do_push;
            data = 8'h80 + 8'(pushed);
            #1;
            if (ready && q.size() != 0) begin
                check("wrap_head", d4_data, q[0]);
                void'(q.pop_front());
            end
            if (do_push) begin
                q.push_back(32'h80 + pushed);
                pushed++;
            end
            cycle();
            check("wrap_level", d4_level, q.size());
            check("wrap_le4", d4_level <= 3'd4, 1);
            check("wrap_full", d4_full, q.size() == 4);
            cyc++;
        end
        valid = 1'b0; ready = 1'b0;
        check("wrap_done", cyc < 1000, 1);
        check("wrap_ovf", d4_ovf, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
